// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the loadable instruction memory:
//   - opcode field width and opcode constants of the CPU instruction set
//   - NOP word for the default 16-bit instruction format
//   - state encoding of the memory controller (CLEAR / RUN)
// An instruction word is {opcode[OPC_W-1:0], operand}.
// -----------------------------------------------------------------------------
package instr_mem_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OPC_LDCA = 4'h1;
    localparam logic [OPC_W-1:0] OPC_LDCB = 4'h2;
    localparam logic [OPC_W-1:0] OPC_ADDA = 4'h3;
    localparam logic [OPC_W-1:0] OPC_STA  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_JMP  = 4'h5;
    localparam logic [OPC_W-1:0] OPC_JZ   = 4'h6;
    // NOP is deliberately non-zero so an all-zero (never written) word
    // cannot be mistaken for a cleared one.
    localparam logic [OPC_W-1:0] OPC_NOP  = 4'hF;

    // NOP word for the default 16-bit format: opcode NOP, operand 0.
    localparam logic [15:0] NOP_WORD16 = {OPC_NOP, 12'h000};

    // Controller state encoding.
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/instr_mem_array.sv
// -----------------------------------------------------------------------------
// instr_mem_array
// Plain DEPTH x W storage: one synchronous write port, one synchronous read
// port. A read and a write to the same address on the same edge return the
// old word (read-first). The storage itself has no reset.
// Ports:
//   clk_i      clock, rising edge
//   we_i       write enable
//   waddr_i    write address (caller keeps it below DEPTH)
//   wdata_i    write data
//   re_i       read enable; rdata_o updates only when set
//   raddr_i    read address (caller keeps it below DEPTH when re_i=1)
//   rdata_o    registered read data
// -----------------------------------------------------------------------------
module instr_mem_array #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int W      = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [W-1:0]      wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [W-1:0]      rdata_o
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    // Non-blocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
// Loadable program memory in front of the CPU fetch stage. After reset it
// writes NOP into every word (CLEAR, DEPTH cycles), then serves fetches with
// one cycle latency and accepts runtime program loads (RUN).
//
// Handshakes (valid/ready):
//   - Fetch is taken on a rising edge where Fetch=1 and FetchReady=1; the
//     result appears on Instr with a one-cycle InstrValid pulse after that
//     edge. Without a new fetch Instr holds its last value.
//   - A load is taken on a rising edge where LoadValid=1 and LoadReady=1;
//     the word is written at that edge. Out-of-range loads are dropped.
//   Both ready signals are low during CLEAR; requests then have no effect.
//
// Configuration macro: INSTR_MEM_PARITY_EN
//   defined   : each word carries an even-parity bit; a fetched word whose
//               parity fails returns NOP with ParityErr=1 alongside InstrValid.
//   undefined : no parity storage, ParityErr is constant 0.
//
// Ports:
//   Clock       clock, rising edge
//   Reset       asynchronous, active-high reset
//   Ip          fetch address
//   Fetch       fetch request
//   FetchReady  memory accepts fetches (RUN)
//   Instr       fetched instruction
//   InstrValid  one-cycle pulse, Instr carries a new fetch result
//   LoadValid   load request
//   LoadAddr    load address
//   LoadData    load word
//   LoadReady   memory accepts loads (RUN)
//   ParityErr   one-cycle pulse, fetched word was corrupted
//   DbgState    controller state (ST_CLEAR / ST_RUN)
// -----------------------------------------------------------------------------
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Ip,
    input  logic              Fetch,
    output logic              FetchReady,
    output logic [DATA_W-1:0] Instr,
    output logic              InstrValid,
    input  logic              LoadValid,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    output logic              LoadReady,
    output logic              ParityErr,
    output logic [0:0]        DbgState
);

    localparam logic [DATA_W-1:0] NOP_W = {OPC_NOP, {(DATA_W-OPC_W){1'b0}}};

`ifdef INSTR_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              fetch_q, fetch_d;   // a fetch result is due this cycle
    logic              oob_q, oob_d;       // that fetch addressed past DEPTH
    logic [DATA_W-1:0] hold_q, hold_d;     // last value driven on Instr

    logic              running;
    logic              clr_last;
    logic              fetch_in_range;
    logic              load_in_range;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [MEM_W-1:0]  wr_word;
    logic              rd_en;
    logic [MEM_W-1:0]  rd_word;
    logic              par_bad;

    assign running        = (state_q == ST_RUN);
    assign clr_last       = (32'(clr_cnt_q) == DEPTH - 1);
    assign fetch_in_range = (32'(Ip) < DEPTH);
    assign load_in_range  = (32'(LoadAddr) < DEPTH);

    // CLEAR owns the write port; loads only reach it in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_cnt_q;
        wr_data = NOP_W;
        if (!running) begin
            wr_en = 1'b1;
        end else if (LoadValid && load_in_range) begin
            wr_en   = 1'b1;
            wr_addr = LoadAddr;
            wr_data = LoadData;
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    // Stored parity bit makes the XOR of the whole stored word zero.
    assign wr_word = {^wr_data, wr_data};
    assign par_bad = ^rd_word;
`else
    assign wr_word = wr_data;
    assign par_bad = 1'b0;
`endif

    // Out-of-range fetches skip the array; the result is forced to NOP.
    assign rd_en = running && Fetch && fetch_in_range;

    instr_mem_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .W      (MEM_W)
    ) u_array (
        .clk_i   (Clock),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_word),
        .re_i    (rd_en),
        .raddr_i (Ip),
        .rdata_o (rd_word)
    );

    // Output selection: new result when a fetch completed, else hold.
    always_comb begin
        Instr = hold_q;
        if (fetch_q) begin
            if (oob_q || par_bad) begin
                Instr = NOP_W;
            end else begin
                Instr = rd_word[DATA_W-1:0];
            end
        end
    end

    assign InstrValid = fetch_q;
    assign ParityErr  = fetch_q && !oob_q && par_bad;
    assign FetchReady = running;
    assign LoadReady  = running;
    assign DbgState   = state_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (!running) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_last) begin
                state_d = ST_RUN;
            end
        end
        fetch_d = running && Fetch;
        oob_d   = running && Fetch && !fetch_in_range;
        hold_d  = Instr;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            fetch_q   <= 1'b0;
            oob_q     <= 1'b0;
            hold_q    <= NOP_W;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            fetch_q   <= fetch_d;
            oob_q     <= oob_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_instr_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_mem
// Directed bench for instr_mem: a DEPTH=1024 instance for the main checks and
// a DEPTH=16 instance for out-of-range fetch/load behaviour.
// -----------------------------------------------------------------------------
module tb_instr_mem;

    localparam logic [15:0] NOP = 16'hF000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (DEPTH=1024) ----------------
    logic [9:0]  ip = '0;
    logic        fetch = 1'b0;
    logic        fetch_ready;
    logic [15:0] instr;
    logic        instr_valid;
    logic        load_valid = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic        parity_err;
    logic [0:0]  dbg_state;

    instr_mem #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024)) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Ip         (ip),
        .Fetch      (fetch),
        .FetchReady (fetch_ready),
        .Instr      (instr),
        .InstrValid (instr_valid),
        .LoadValid  (load_valid),
        .LoadAddr   (load_addr),
        .LoadData   (load_data),
        .LoadReady  (load_ready),
        .ParityErr  (parity_err),
        .DbgState   (dbg_state)
    );

    // ---------------- small DUT (DEPTH=16) ----------------
    logic [9:0]  s_ip = '0;
    logic        s_fetch = 1'b0;
    logic        s_fetch_ready;
    logic [15:0] s_instr;
    logic        s_instr_valid;
    logic        s_load_valid = 1'b0;
    logic [9:0]  s_load_addr = '0;
    logic [15:0] s_load_data = '0;
    logic        s_load_ready;
    logic        s_parity_err;
    logic [0:0]  s_dbg_state;

    instr_mem #(.ADDR_W(10), .DATA_W(16), .DEPTH(16)) dut_s (
        .Clock      (clk),
        .Reset      (rst),
        .Ip         (s_ip),
        .Fetch      (s_fetch),
        .FetchReady (s_fetch_ready),
        .Instr      (s_instr),
        .InstrValid (s_instr_valid),
        .LoadValid  (s_load_valid),
        .LoadAddr   (s_load_addr),
        .LoadData   (s_load_data),
        .LoadReady  (s_load_ready),
        .ParityErr  (s_parity_err),
        .DbgState   (s_dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [15:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        step();
        load_valid = 1'b0;
    endtask

    // Walk through the CLEAR phase: FetchReady must stay low for 1024 cycles
    // after Reset falls and be high on the next one.
    task automatic wait_clear(input string tag);
        int lows = 0;
        int vpulses = 0;
        for (int i = 0; i < 1024; i++) begin
            if (!fetch_ready) lows++;
            if (instr_valid) vpulses++;
            step();
        end
        chk({tag, "_ready_low_cycles"}, lows, 1024);
        chk({tag, "_no_valid_in_clear"}, vpulses, 0);
        chk({tag, "_fetch_ready_up"}, fetch_ready, 1'b1);
        chk({tag, "_load_ready_up"}, load_ready, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    logic [15:0] burst_data [4];

    initial begin
        burst_data[0] = 16'h1011;
        burst_data[1] = 16'h2022;
        burst_data[2] = 16'h3033;
        burst_data[3] = 16'h5044;

        // Reset values while Reset is held.
        step();
        step();
        chk("rst_instr", instr, NOP);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_fetch_ready", fetch_ready, 1'b0);
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_parity", parity_err, 1'b0);
        chk("rst_state", dbg_state, 1'b0);

        // Release reset; a fetch request held through CLEAR must be ignored.
        rst   = 1'b0;
        fetch = 1'b1;
        ip    = 10'd5;
        wait_clear("clr1");
        chk("run_state", dbg_state, 1'b1);

        // First fetch after CLEAR: word 5 is NOP.
        step();
        chk("f5_instr", instr, NOP);
        chk("f5_valid", instr_valid, 1'b1);
        chk("f5_parity", parity_err, 1'b0);
        fetch = 1'b0;
        step();
        chk("idle_valid", instr_valid, 1'b0);
        chk("idle_hold", instr, NOP);

        // Load then fetch on the following edge; unloaded neighbour is NOP.
        load_word(10'd1, 16'h1A00);
        fetch = 1'b1;
        ip    = 10'd1;
        step();
        chk("f1_instr", instr, 16'h1A00);
        chk("f1_valid", instr_valid, 1'b1);
        ip = 10'd2;
        step();
        chk("f2_instr", instr, NOP);
        chk("f2_valid", instr_valid, 1'b1);
        fetch = 1'b0;
        step();
        chk("f2_hold_valid", instr_valid, 1'b0);
        chk("f2_hold_instr", instr, NOP);

        // Same-cycle load and fetch at one address: read-first.
        load_word(10'd9, 16'h1234);
        load_valid = 1'b1;
        load_addr  = 10'd9;
        load_data  = 16'hBEEF;
        fetch      = 1'b1;
        ip         = 10'd9;
        step();
        load_valid = 1'b0;
        chk("rf_old", instr, 16'h1234);
        step();
        chk("rf_new", instr, 16'hBEEF);
        chk("rf_new_valid", instr_valid, 1'b1);
        fetch = 1'b0;

        // Back-to-back fetches: one result per cycle.
        for (int i = 0; i < 4; i++) load_word(10'(10 + i), burst_data[i]);
        fetch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ip = 10'(10 + i);
            step();
            chk($sformatf("b2b_instr%0d", i), instr, burst_data[i]);
            chk($sformatf("b2b_valid%0d", i), instr_valid, 1'b1);
        end
        fetch = 1'b0;
        step();
        chk("b2b_end_valid", instr_valid, 1'b0);
        chk("b2b_end_hold", instr, burst_data[3]);

        // DEPTH=16 instance: out-of-range fetch and dropped load.
        s_load_valid = 1'b1;
        s_load_addr  = 10'd4;
        s_load_data  = 16'h3004;
        step();
        s_load_valid = 1'b0;
        s_fetch = 1'b1;
        s_ip    = 10'd20;
        step();
        chk("oob_instr", s_instr, NOP);
        chk("oob_valid", s_instr_valid, 1'b1);
        chk("oob_parity", s_parity_err, 1'b0);
        s_fetch      = 1'b0;
        s_load_valid = 1'b1;
        s_load_addr  = 10'd20;
        s_load_data  = 16'h5555;
        step();
        s_load_valid = 1'b0;
        s_fetch = 1'b1;
        s_ip    = 10'd4;
        step();
        chk("oob_load_dropped", s_instr, 16'h3004);
        chk("oob_load_valid", s_instr_valid, 1'b1);
        s_fetch = 1'b0;

        // Parity handling on word 7.
        load_word(10'd7, 16'h4007);
`ifdef INSTR_MEM_PARITY_EN
        dut.u_array.mem[7][0] = ~dut.u_array.mem[7][0];
        fetch = 1'b1;
        ip    = 10'd7;
        step();
        fetch = 1'b0;
        chk("par_instr", instr, NOP);
        chk("par_valid", instr_valid, 1'b1);
        chk("par_err", parity_err, 1'b1);
        step();
        chk("par_err_pulse", parity_err, 1'b0);
`else
        fetch = 1'b1;
        ip    = 10'd7;
        step();
        fetch = 1'b0;
        chk("nopar_instr", instr, 16'h4007);
        chk("nopar_err", parity_err, 1'b0);
        step();
        chk("nopar_err_idle", parity_err, 1'b0);
`endif

        // Mid-stream reset after loading word 3.
        load_word(10'd3, 16'h2C00);
        fetch = 1'b1;
        ip    = 10'd3;
        step();
        chk("pre_rst_instr", instr, 16'h2C00);
        rst = 1'b1;
        #1;
        chk("mid_rst_instr", instr, NOP);
        chk("mid_rst_valid", instr_valid, 1'b0);
        chk("mid_rst_fetch_ready", fetch_ready, 1'b0);
        chk("mid_rst_load_ready", load_ready, 1'b0);
        chk("mid_rst_state", dbg_state, 1'b0);
        step();
        rst = 1'b0;
        wait_clear("clr2");
        step();
        chk("post_clr_f3", instr, NOP);
        chk("post_clr_f3_valid", instr_valid, 1'b1);
        fetch = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
# instr_mem

Parametrised, loadable program memory that supersedes the fixed case-table instruction ROM in front of the CPU fetch stage. It holds DEPTH instruction words, clears itself to NOP after reset, serves registered fetches through a request/valid handshake, and accepts program words at runtime through a write port. Sits between the program-counter logic (Ip) and the decode stage (Instr).

## Interface
- ADDR_W, 10, fetch/load address width
- DATA_W, 16, instruction width (opcode + operand)
- DEPTH, 1024, number of words; must be ≤ 2**ADDR_W
- Clock  in  1  single clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high
- Ip  in  ADDR_W  fetch address
- Fetch  in  1  fetch request, sampled when FetchReady=1
- FetchReady  out  1  memory can accept a fetch
- Instr  out  DATA_W  fetched instruction, registered
- InstrValid  out  1  one-cycle pulse: Instr holds a new fetch result
- LoadValid  in  1  load request
- LoadAddr  in  ADDR_W  load address
- LoadData  in  DATA_W  load word
- LoadReady  out  1  load accepted when LoadValid & LoadReady
- ParityErr  out  1  one-cycle pulse on corrupted fetch word

## Operation
- States: CLEAR, RUN.
- Reset (async): state=CLEAR, clear counter=0, Instr=NOP word, InstrValid=0, FetchReady=0, LoadReady=0, ParityErr=0.
- CLEAR: each cycle writes NOP to word[counter], counter++; after writing DEPTH-1 go to RUN next cycle. Fetch and LoadValid ignored (no side effect, no response).
- RUN: FetchReady=1, LoadReady=1.
- Fetch accepted (Fetch=1 in RUN): next cycle Instr=word[Ip], InstrValid=1. No fetch: Instr holds last value, InstrValid=0.
- Ip ≥ DEPTH: Instr=NOP word, InstrValid=1, no error.
- Load accepted: word[LoadAddr]=LoadData at that edge. LoadAddr ≥ DEPTH: write dropped silently.
- Fetch and load to same address in same cycle: read-first, Instr returns old word; new word visible to fetches from next cycle.
- Back-to-back fetches every cycle: one result per cycle, full throughput.
- Reset asserted mid-RUN or mid-CLEAR: immediate return to reset values; memory contents re-cleared by new CLEAR pass.

## Timing
- Fetch latency: 1 cycle (request edge → Instr/InstrValid at next edge).
- Load latency: write at accept edge; readable by a fetch accepted on the following edge.
- CLEAR duration: exactly DEPTH cycles after Reset deasserts; FetchReady rises on cycle DEPTH+1.
- ParityErr aligned with the InstrValid pulse it qualifies.

## Configuration
- INSTR_MEM_PARITY_EN defined: each word stored with one extra even-parity bit computed on load/clear; on fetch, mismatch → Instr=NOP word, InstrValid=1, ParityErr=1 for that cycle.
- Not defined: no parity storage; ParityErr tied 0; port retained for a stable interface.

## Structure
- Shared package: opcode constants (NOP, LDCA, LDCB, ADDA, STA, JMP, ...), opcode field width, NOP word constant (opcode NOP, operand 0), state encoding for CLEAR/RUN.
- One sub-module: instr_mem_array — pure DEPTH×(DATA_W[+1]) storage, one sync read port (read-first), one write port; instr_mem holds FSM, clear counter, muxing and parity.

## Test plan
- Reset, DEPTH=1024: FetchReady=0 for 1024 cycles, then 1; fetch Ip=5 → Instr=NOP word, InstrValid=1 next cycle.
- Load 0x1A00 at addr 1, fetch Ip=1 next cycle → Instr=0x1A00 one cycle later; fetch of unloaded addr 2 → NOP.
- Same-cycle load 0xBEEF and fetch at addr 9 (old 0x1234) → Instr=0x1234; refetch → 0xBEEF.
- DEPTH=16, fetch Ip=20 → NOP, ParityErr=0; load to 20 then fetch Ip=4 → unchanged.
- Reset pulse after loading 0x2C00 at addr 3 mid-stream → outputs to reset values instantly; after new CLEAR, fetch Ip=3 → NOP.
- INSTR_MEM_PARITY_EN: force flipped bit in word 7 → fetch Ip=7 gives Instr=NOP, ParityErr=1 one cycle; without macro ParityErr stays 0.
